// File: rtl/ahb3lite_mem_slave.sv
// AHB3-Lite memory slave: decodes one address window, inserts WAIT_STATES per
// transfer, and drives an asynchronous-read / strobed-write memory port.
module ahb3lite_mem_slave #(
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE   = 32'h0000_1000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [31:0] mem_WR_addr,
  output logic        mem_write_flag,
  output logic [31:0] HWDATA_toMem,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_RD_addr,
  input  logic [31:0] mem_RDATA
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t      r_state, w_nxt;
  logic [2:0]  r_cnt;
  logic [31:0] r_off;
  logic [1:0]  r_size;
  logic        r_write;

  logic [31:0] w_off;
  logic        w_req, w_open, w_accept, w_misal, w_oor, w_err, w_last;
  logic [3:0]  w_ben;
  logic        w_unused;

  assign w_unused = ^HBURST;

  assign w_off    = HADDR - ADDR_BASE;
  assign w_req    = HSEL & HREADY & HTRANS[1];
  assign w_last   = (r_state == S_DATA) && (r_cnt == 3'd0);
  // ERR1 and wait cycles never take a new address phase
  assign w_open   = (r_state == S_IDLE) || (r_state == S_ERR2) || w_last;
  assign w_accept = w_req & w_open;
  assign w_misal  = ((HSIZE == 3'b001) & HADDR[0]) | ((HSIZE == 3'b010) & (|HADDR[1:0]));
  assign w_oor    = (HADDR < ADDR_BASE) | (w_off >= ADDR_SIZE);
  assign w_err    = (HSIZE > 3'b010) | w_misal | w_oor;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: w_nxt = S_IDLE;
      S_DATA: w_nxt = (r_cnt != 3'd0) ? S_DATA : S_IDLE;
      S_ERR1: w_nxt = S_ERR2;
      S_ERR2: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    if (w_accept) w_nxt = w_err ? S_ERR1 : S_DATA;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_cnt   <= 3'd0;
      r_off   <= 32'h0;
      r_size  <= 2'd0;
      r_write <= 1'b0;
    end else begin
      if (w_accept && !w_err) begin
        r_cnt   <= 3'(WAIT_STATES);
        r_off   <= w_off;
        r_size  <= HSIZE[1:0];
        r_write <= HWRITE;
      end else if (r_state == S_DATA && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  always_comb begin
    case (r_size)
      2'd0:    w_ben = 4'b0001 << r_off[1:0];
      2'd1:    w_ben = 4'b0011 << r_off[1:0];
      default: w_ben = 4'b1111;
    endcase
  end

  always_comb begin
    HREADYOUT      = 1'b1;
    HRESP          = 1'b0;
    mem_write_flag = 1'b0;
    HWDATA_toMem   = 32'h0;
    mem_byte_en    = 4'b0000;
    HRDATA         = 32'h0;
    mem_WR_addr    = {r_off[31:2], 2'b00};
    mem_RD_addr    = {r_off[31:2], 2'b00};
    case (r_state)
      S_DATA: begin
        HREADYOUT = (r_cnt == 3'd0);
        if (w_last && r_write) begin
          mem_write_flag = 1'b1;
          HWDATA_toMem   = HWDATA;
          mem_byte_en    = w_ben;
        end
        if (w_last && !r_write) HRDATA = mem_RDATA;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb3lite_mem_slave.sv
// Directed bench: three slaves (WAIT_STATES 0/2/3) share the bus inputs, each
// selected on its own HSEL with HREADY looped back from its HREADYOUT.
module tb_ahb3lite_mem_slave;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [2:0]  sel;
  logic [31:0] haddr, hwdata, rdata;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [1:0]  htrans;

  logic        hro [3];
  logic        hrsp[3];
  logic        wfl [3];
  logic [31:0] hrd [3];
  logic [31:0] wra [3];
  logic [31:0] wdm [3];
  logic [31:0] rda [3];
  logic [3:0]  ben [3];

  int n_chk = 0, n_bad = 0, s0 = 0;
  int nstb[3] = '{0, 0, 0};

  always #5 HCLK = ~HCLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    ahb3lite_mem_slave #(.WAIT_STATES(WS)) u_dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel[g]), .HADDR(haddr),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans),
      .HWDATA(hwdata), .HREADY(hro[g]), .HREADYOUT(hro[g]), .HRESP(hrsp[g]),
      .HRDATA(hrd[g]), .mem_WR_addr(wra[g]), .mem_write_flag(wfl[g]),
      .HWDATA_toMem(wdm[g]), .mem_byte_en(ben[g]), .mem_RD_addr(rda[g]),
      .mem_RDATA(rdata)
    );
  end

  // write strobes counted once per cycle, mid-cycle
  always @(negedge HCLK) for (int i = 0; i < 3; i++) if (wfl[i]) nstb[i]++;

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task ap(input int i, input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [1:0] tr);
    sel = 3'b000; sel[i] = 1'b1;
    haddr = a; hwrite = w; hsize = sz; htrans = tr;
  endtask

  task idle();
    sel = 3'b000; htrans = T_IDLE;
  endtask

  initial begin
    sel = 3'b000; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0;
    htrans = T_IDLE; hwdata = 32'h0; rdata = 32'h0;
    repeat (2) @(negedge HCLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_hready", 32'(hro[i]), 32'd1);
      chk("rst_hresp",  32'(hrsp[i]), 32'd0);
      chk("rst_wflag",  32'(wfl[i]), 32'd0);
      chk("rst_ben",    32'(ben[i]), 32'd0);
      chk("rst_wraddr", wra[i], 32'h0);
      chk("rst_rdaddr", rda[i], 32'h0);
      chk("rst_wdata",  wdm[i], 32'h0);
      chk("rst_rdata",  hrd[i], 32'h0);
    end
    HRESETn = 1'b1;

    // word write, zero wait
    @(negedge HCLK); ap(0, 32'h10, 1'b1, 3'd2, T_NSEQ);
    @(negedge HCLK); idle(); hwdata = 32'hDEADBEEF; #1;
    chk("w_hready", 32'(hro[0]), 32'd1);
    chk("w_flag",   32'(wfl[0]), 32'd1);
    chk("w_addr",   wra[0], 32'h10);
    chk("w_ben",    32'(ben[0]), 32'hF);
    chk("w_data",   wdm[0], 32'hDEADBEEF);
    chk("w_resp",   32'(hrsp[0]), 32'd0);
    @(negedge HCLK); #1;
    chk("w_flag_end", 32'(wfl[0]), 32'd0);
    chk("w_data_end", wdm[0], 32'h0);

    // read with two wait states
    @(negedge HCLK); ap(1, 32'h20, 1'b0, 3'd2, T_NSEQ); rdata = 32'h12345678;
    @(negedge HCLK); idle(); #1;
    chk("r_rdy0", 32'(hro[1]), 32'd0);
    chk("r_addr", rda[1], 32'h20);
    chk("r_data_wait", hrd[1], 32'h0);
    @(negedge HCLK); #1;
    chk("r_rdy1", 32'(hro[1]), 32'd0);
    @(negedge HCLK); #1;
    chk("r_rdy2", 32'(hro[1]), 32'd1);
    chk("r_data", hrd[1], 32'h12345678);
    @(negedge HCLK); #1;
    chk("r_data_idle", hrd[1], 32'h0);

    // halfword write upper lanes, then misaligned halfword
    @(negedge HCLK); ap(0, 32'h6, 1'b1, 3'd1, T_NSEQ);
    @(negedge HCLK); idle(); hwdata = 32'hBEEF0000; #1;
    chk("hw_ben",  32'(ben[0]), 32'hC);
    chk("hw_flag", 32'(wfl[0]), 32'd1);
    chk("hw_addr", wra[0], 32'h4);
    chk("hw_data", wdm[0], 32'hBEEF0000);
    @(negedge HCLK); ap(0, 32'h5, 1'b1, 3'd1, T_NSEQ);
    @(negedge HCLK); idle(); #1;
    chk("mis_e1_rdy",  32'(hro[0]), 32'd0);
    chk("mis_e1_resp", 32'(hrsp[0]), 32'd1);
    chk("mis_e1_flag", 32'(wfl[0]), 32'd0);
    @(negedge HCLK); #1;
    chk("mis_e2_rdy",  32'(hro[0]), 32'd1);
    chk("mis_e2_resp", 32'(hrsp[0]), 32'd1);
    chk("mis_e2_flag", 32'(wfl[0]), 32'd0);
    @(negedge HCLK); #1;
    chk("mis_done_resp", 32'(hrsp[0]), 32'd0);
    chk("mis_done_rdy",  32'(hro[0]), 32'd1);

    // INCR4 with a BUSY between beats 2 and 3
    s0 = nstb[0]; hburst = 3'b011;
    @(negedge HCLK); ap(0, 32'h0, 1'b1, 3'd2, T_NSEQ);
    @(negedge HCLK); ap(0, 32'h4, 1'b1, 3'd2, T_SEQ); hwdata = 32'h100; #1;
    chk("b0_flag", 32'(wfl[0]), 32'd1);
    chk("b0_addr", wra[0], 32'h0);
    @(negedge HCLK); ap(0, 32'h8, 1'b1, 3'd2, T_BUSY); hwdata = 32'h104; #1;
    chk("b1_flag", 32'(wfl[0]), 32'd1);
    chk("b1_addr", wra[0], 32'h4);
    chk("b1_data", wdm[0], 32'h104);
    @(negedge HCLK); ap(0, 32'h8, 1'b1, 3'd2, T_SEQ); #1;
    chk("busy_flag", 32'(wfl[0]), 32'd0);
    chk("busy_rdy",  32'(hro[0]), 32'd1);
    @(negedge HCLK); ap(0, 32'hC, 1'b1, 3'd2, T_SEQ); hwdata = 32'h108; #1;
    chk("b2_flag", 32'(wfl[0]), 32'd1);
    chk("b2_addr", wra[0], 32'h8);
    chk("b2_data", wdm[0], 32'h108);
    @(negedge HCLK); idle(); hwdata = 32'h10C; #1;
    chk("b3_flag", 32'(wfl[0]), 32'd1);
    chk("b3_addr", wra[0], 32'hC);
    @(negedge HCLK); #1;
    chk("incr_end_flag", 32'(wfl[0]), 32'd0);
    chk("incr_strobes", nstb[0] - s0, 32'd4);
    hburst = 3'd0;

    // first address past the window, then last word inside it
    @(negedge HCLK); ap(0, 32'h1000, 1'b0, 3'd2, T_NSEQ);
    @(negedge HCLK); idle(); #1;
    chk("oor_e1_rdy",  32'(hro[0]), 32'd0);
    chk("oor_e1_resp", 32'(hrsp[0]), 32'd1);
    @(negedge HCLK); #1;
    chk("oor_e2_rdy",  32'(hro[0]), 32'd1);
    chk("oor_e2_resp", 32'(hrsp[0]), 32'd1);
    @(negedge HCLK); ap(0, 32'hFFC, 1'b0, 3'd2, T_NSEQ); rdata = 32'hCAFEF00D;
    @(negedge HCLK); idle(); #1;
    chk("top_resp",  32'(hrsp[0]), 32'd0);
    chk("top_rdata", hrd[0], 32'hCAFEF00D);
    chk("top_raddr", rda[0], 32'hFFC);

    // reset in the middle of a three-wait write
    s0 = nstb[2];
    @(negedge HCLK); ap(2, 32'h40, 1'b1, 3'd2, T_NSEQ);
    @(negedge HCLK); idle(); hwdata = 32'h55; #1;
    chk("ws3_rdy",  32'(hro[2]), 32'd0);
    chk("ws3_addr", wra[2], 32'h40);
    @(negedge HCLK); HRESETn = 1'b0;
    @(negedge HCLK); HRESETn = 1'b1; #1;
    chk("mrst_rdy",    32'(hro[2]), 32'd1);
    chk("mrst_resp",   32'(hrsp[2]), 32'd0);
    chk("mrst_flag",   32'(wfl[2]), 32'd0);
    chk("mrst_wraddr", wra[2], 32'h0);
    chk("mrst_rdaddr", rda[2], 32'h0);
    chk("mrst_ben",    32'(ben[2]), 32'd0);
    chk("mrst_wdata",  wdm[2], 32'h0);
    chk("mrst_rdata",  hrd[2], 32'h0);
    repeat (4) @(negedge HCLK);
    #1;
    chk("mrst_strobes", nstb[2] - s0, 32'd0);
    chk("mrst_rdy_end", 32'(hro[2]), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
